// File: rtl/line_fifo_sequencer.sv
// Sequencer for the multi-line RAM FIFO in the vertical scaler: write addressing per input
// line, fixed-point vertical stepping on the read side, and end-of-frame drain.
module line_fifo_sequencer #(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned ADDRESS_WIDTH = 10,
  parameter int unsigned BUFFER_SIZE   = 4,
  parameter int unsigned FILL_WIDTH    = 3,
  parameter int unsigned SCALE_FRAC    = 14,
  parameter int unsigned LINES_WIDTH   = 11
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_start,
  input  logic [ADDRESS_WIDTH-1:0] i_in_width,
  input  logic [LINES_WIDTH-1:0]   i_in_height,
  input  logic [LINES_WIDTH-1:0]   i_out_height,
  input  logic [SCALE_FRAC+1:0]    i_v_step,
  input  logic                     i_in_valid,
  input  logic [DATA_WIDTH-1:0]    i_in_data,
  output logic                     o_in_ready,
  output logic [DATA_WIDTH-1:0]    o_fifo_write_data,
  output logic [ADDRESS_WIDTH-1:0] o_fifo_write_address,
  output logic                     o_fifo_write_enable,
  output logic                     o_fifo_advance_write,
  output logic                     o_fifo_advance_read1,
  output logic                     o_fifo_advance_read2,
  output logic                     o_fifo_force_read,
  input  logic [FILL_WIDTH-1:0]    i_fifo_fill_count,
  output logic                     o_line_valid,
  output logic [SCALE_FRAC-1:0]    o_line_frac,
  input  logic                     i_line_done,
  output logic                     o_busy,
  output logic                     o_frame_done
);

  localparam int unsigned StepW = SCALE_FRAC + 2;
  localparam logic [StepW-1:0]      StepMax     = {2'b10, {SCALE_FRAC{1'b0}}};
  localparam logic [FILL_WIDTH-1:0] FillWrLimit = FILL_WIDTH'(BUFFER_SIZE - 1);

  typedef enum logic [2:0] {
    StIdle, StWait, StReady, StAdv, StSettle, StDrain, StDone
  } state_e;

  state_e r_state, w_state_d;

  logic [ADDRESS_WIDTH-1:0] r_in_width;
  logic [LINES_WIDTH-1:0]   r_in_height;
  logic [LINES_WIDTH-1:0]   r_out_height;
  logic [StepW-1:0]         r_v_step;
  logic [StepW-1:0]         w_v_step_clamp;

  logic [ADDRESS_WIDTH-1:0] r_wr_addr;
  logic [LINES_WIDTH-1:0]   r_lines_written;
  logic                     r_adv_write;
  logic                     r_adv_write_q;

  logic [LINES_WIDTH-1:0]   r_lines_out, w_lines_out_d, w_lines_out_inc;
  logic [SCALE_FRAC-1:0]    r_y_frac, w_y_frac_d;
  logic [1:0]               r_delta, w_delta_d, w_delta_eff;
  logic                     r_drain_pulse, w_drain_pulse_d;

  logic                     w_start_accept;
  logic                     w_busy;
  logic                     w_input_complete;
  logic                     w_in_ready;
  logic                     w_accept;
  logic                     w_last_pix;
  logic [StepW-1:0]         w_sum;
  logic [FILL_WIDTH-1:0]    w_fill_m1;

  assign w_start_accept   = i_start && (r_state == StIdle);
  assign w_busy           = (r_state != StIdle) && (r_state != StDone);
  assign w_input_complete = (r_lines_written == r_in_height);
  assign w_in_ready       = w_busy && (r_lines_written < r_in_height) &&
                            (i_fifo_fill_count < FillWrLimit) && !r_adv_write_q;
  assign w_accept         = i_in_valid && w_in_ready;
  assign w_last_pix       = w_accept && (r_wr_addr == r_in_width);
  assign w_lines_out_inc  = r_lines_out + LINES_WIDTH'(1);
  assign w_sum            = {2'b00, r_y_frac} + r_v_step;
  assign w_fill_m1        = i_fifo_fill_count - FILL_WIDTH'(1);

  assign o_in_ready           = w_in_ready;
  assign o_fifo_write_data    = i_in_data;
  assign o_fifo_write_address = r_wr_addr;
  assign o_fifo_write_enable  = w_accept;
  assign o_fifo_advance_write = r_adv_write;
  assign o_fifo_force_read    = w_busy && w_input_complete;
  assign o_busy               = w_busy;

  // Step of zero would stall the frame; more than two lines per output line cannot be advanced.
  always_comb begin
    w_v_step_clamp = i_v_step;
    if (i_v_step == '0) begin
      w_v_step_clamp = StepW'(1);
    end else if (i_v_step > StepMax) begin
      w_v_step_clamp = StepMax;
    end
  end

  // Once input is complete, keep the last line resident so the bottom edge can be replicated.
  always_comb begin
    w_delta_eff = r_delta;
    if (w_input_complete && (FILL_WIDTH'(r_delta) > w_fill_m1)) begin
      w_delta_eff = w_fill_m1[1:0];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_in_width   <= '0;
      r_in_height  <= '0;
      r_out_height <= '0;
      r_v_step     <= '0;
    end else if (w_start_accept) begin
      r_in_width   <= i_in_width;
      r_in_height  <= i_in_height;
      r_out_height <= i_out_height;
      r_v_step     <= w_v_step_clamp;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || w_start_accept) begin
      r_wr_addr       <= '0;
      r_lines_written <= '0;
      r_adv_write     <= 1'b0;
      r_adv_write_q   <= 1'b0;
    end else begin
      r_adv_write   <= w_last_pix;
      r_adv_write_q <= r_adv_write;
      if (w_accept) begin
        if (w_last_pix) begin
          r_wr_addr       <= '0;
          r_lines_written <= r_lines_written + LINES_WIDTH'(1);
        end else begin
          r_wr_addr <= r_wr_addr + ADDRESS_WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= StIdle;
      r_lines_out   <= '0;
      r_y_frac      <= '0;
      r_delta       <= '0;
      r_drain_pulse <= 1'b0;
    end else if (w_start_accept) begin
      r_state       <= w_state_d;
      r_lines_out   <= '0;
      r_y_frac      <= '0;
      r_delta       <= '0;
      r_drain_pulse <= 1'b0;
    end else begin
      r_state       <= w_state_d;
      r_lines_out   <= w_lines_out_d;
      r_y_frac      <= w_y_frac_d;
      r_delta       <= w_delta_d;
      r_drain_pulse <= w_drain_pulse_d;
    end
  end

  always_comb begin
    w_state_d            = r_state;
    w_lines_out_d        = r_lines_out;
    w_y_frac_d           = r_y_frac;
    w_delta_d            = r_delta;
    w_drain_pulse_d      = 1'b0;
    o_fifo_advance_read1 = 1'b0;
    o_fifo_advance_read2 = 1'b0;
    o_line_valid         = 1'b0;
    o_line_frac          = '0;
    o_frame_done         = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (i_start) w_state_d = StWait;
      end
      StWait: begin
        if ((i_fifo_fill_count >= FILL_WIDTH'(2)) ||
            (w_input_complete && (i_fifo_fill_count >= FILL_WIDTH'(1)))) begin
          w_state_d = StReady;
        end
      end
      StReady: begin
        o_line_valid = 1'b1;
        o_line_frac  = (i_fifo_fill_count == FILL_WIDTH'(1)) ? '0 : r_y_frac;
        if (i_line_done) begin
          w_lines_out_d = w_lines_out_inc;
          if (w_lines_out_inc == r_out_height) begin
            w_state_d = StDrain;
          end else begin
            w_delta_d  = w_sum[StepW-1:SCALE_FRAC];
            w_y_frac_d = w_sum[SCALE_FRAC-1:0];
            w_state_d  = StAdv;
          end
        end
      end
      StAdv: begin
        // Hold off while a write advance is landing so the two never coincide.
        if (!r_adv_write) begin
          o_fifo_advance_read1 = (w_delta_eff == 2'd1);
          o_fifo_advance_read2 = (w_delta_eff == 2'd2);
          w_state_d            = StSettle;
        end
      end
      StSettle: begin
        w_state_d = StWait;
      end
      StDrain: begin
        if (!r_drain_pulse && !r_adv_write) begin
          if (i_fifo_fill_count != '0) begin
            o_fifo_advance_read1 = 1'b1;
            w_drain_pulse_d      = 1'b1;
          end else if (w_input_complete) begin
            w_state_d = StDone;
          end
        end
      end
      StDone: begin
        o_frame_done = 1'b1;
        w_state_d    = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

endmodule

// File: tb/tb_line_fifo_sequencer.sv
// Scoreboard bench for line_fifo_sequencer: a fill-count model stands in for the line RAM FIFO.
module tb_line_fifo_sequencer;
  localparam int DW = 8;
  localparam int AW = 10;
  localparam int BS = 4;
  localparam int FW = 3;
  localparam int SF = 14;
  localparam int LW = 11;

  logic          clk = 1'b0;
  logic          rst, start, in_valid, line_done;
  logic [AW-1:0] in_width;
  logic [LW-1:0] in_height, out_height;
  logic [SF+1:0] v_step;
  logic [DW-1:0] in_data;
  logic          in_ready, we, aw, r1, r2, fr, lv, busy, fd;
  logic [DW-1:0] wdata;
  logic [AW-1:0] waddr;
  logic [SF-1:0] frac;
  logic [FW-1:0] fill_cnt;

  always #5 clk = ~clk;

  line_fifo_sequencer dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_in_width(in_width),
    .i_in_height(in_height), .i_out_height(out_height), .i_v_step(v_step),
    .i_in_valid(in_valid), .i_in_data(in_data), .o_in_ready(in_ready),
    .o_fifo_write_data(wdata), .o_fifo_write_address(waddr), .o_fifo_write_enable(we),
    .o_fifo_advance_write(aw), .o_fifo_advance_read1(r1), .o_fifo_advance_read2(r2),
    .o_fifo_force_read(fr), .i_fifo_fill_count(fill_cnt), .o_line_valid(lv),
    .o_line_frac(frac), .i_line_done(line_done), .o_busy(busy), .o_frame_done(fd)
  );

  typedef struct {
    int frac;
    bit chk_fr;
  } line_exp_t;

  line_exp_t q_line[$];
  int        q_adv[$];
  int        n_checks = 0;
  int        n_errors = 0;
  int        done_cnt = 0;
  int        done_base = 0;
  int        px = 0;
  int        exp_addr = 0;
  int        cur_w = 0;
  bit        exp_aw = 0;
  bit        lv_prev = 0;
  bit        hold = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push_line(input int f, input bit c);
    line_exp_t e;
    e.frac   = f;
    e.chk_fr = c;
    q_line.push_back(e);
  endtask

  // Fill count of the FIFO: completed lines in, lines released by read advances out.
  always @(posedge clk) begin
    if (rst) fill_cnt <= '0;
    else fill_cnt <= FW'(int'(fill_cnt) + int'(aw) - int'(r1) - 2 * int'(r2));
  end

  // Downstream reader: finishes each presented line a few cycles later unless held.
  initial begin
    int wait_cnt;
    wait_cnt  = 0;
    line_done = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      line_done = 1'b0;
      if (lv && !hold && !rst) begin
        wait_cnt++;
        if (wait_cnt == 3) begin
          line_done = 1'b1;
          wait_cnt  = 0;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // Monitor: pops expectations whenever the DUT presents a line or a FIFO event.
  initial begin
    line_exp_t e;
    int        k, nf;
    in_data = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        lv_prev  = 0;
        exp_aw   = 0;
        exp_addr = 0;
      end else begin
        if (exp_aw || aw) check("adv_write_timing", int'(aw), int'(exp_aw));
        exp_aw = 0;
        if (we) begin
          check("wr_addr", int'(waddr), exp_addr);
          check("wr_data", int'(wdata), px & 255);
          if (exp_addr == cur_w) begin
            exp_addr = 0;
            exp_aw   = 1;
          end else begin
            exp_addr++;
          end
          px++;
          in_data = DW'(px);
        end
        if (aw || r1 || r2) begin
          nf = int'(fill_cnt) + int'(aw) - int'(r1) - 2 * int'(r2);
          check("fill_in_range", int'(nf >= 0 && nf <= BS - 1), 1);
        end
        if (r1 || r2) begin
          check("rd_exclusive", int'(r1 & r2), 0);
          check("rd_with_wr", int'(aw), 0);
          k = r2 ? 2 : 1;
          if (q_adv.size() == 0) begin
            check("adv_unexpected", k, 0);
          end else begin
            check("adv_kind", k, q_adv.pop_front());
          end
        end
        if (lv && !lv_prev) begin
          if (q_line.size() == 0) begin
            check("line_unexpected", int'(frac), -1);
          end else begin
            e = q_line.pop_front();
            check("line_frac", int'(frac), e.frac);
            if (e.chk_fr) check("force_read_last", int'(fr), 1);
          end
        end
        lv_prev = lv;
        if (fd) begin
          done_cnt++;
          check("busy_at_done", int'(busy), 0);
        end
      end
    end
  end

  task automatic start_frame(input int w, input int ih, input int oh, input int vs);
    in_width   = AW'(w);
    in_height  = LW'(ih);
    out_height = LW'(oh);
    v_step     = (SF + 2)'(vs);
    cur_w      = w;
    done_base  = done_cnt;
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    q_line.delete();
    q_adv.delete();
  endtask

  task automatic wait_done();
    int i;
    for (i = 0; i < 4000 && done_cnt == done_base; i++) @(posedge clk);
    if (done_cnt == done_base) begin
      check("frame_timeout", 0, 1);
      do_reset();
    end else begin
      repeat (6) @(posedge clk);
      check("frame_done_once", done_cnt - done_base, 1);
      check("lines_left", q_line.size(), 0);
      check("advs_left", q_adv.size(), 0);
      check("busy_after", int'(busy), 0);
    end
  endtask

  task automatic push_one_to_one(input int n);
    for (int i = 0; i < n; i++) begin
      push_line(0, 1'b0);
      q_adv.push_back(1);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0;
    in_width = '0; in_height = '0; out_height = '0; v_step = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_outputs", int'(|{in_ready, we, waddr, aw, r1, r2, fr, lv, frac, busy, fd}), 0);
    in_valid = 1'b1;

    // 1:1 scaling, four lines
    push_one_to_one(4);
    start_frame(3, 4, 4, 'h4000);
    wait_done();

    // 2x upscale: blend weights alternate, bottom edge forces zero
    for (int i = 0; i < 8; i++) push_line((i % 2 == 1 && i != 7) ? 'h2000 : 0, i == 7);
    repeat (4) q_adv.push_back(1);
    start_frame(3, 4, 8, 'h2000);
    wait_done();

    // 2x downscale: double advances, then drain the last two lines
    repeat (4) push_line(0, 1'b0);
    repeat (3) q_adv.push_back(2);
    repeat (2) q_adv.push_back(1);
    start_frame(3, 8, 4, 'h8000);
    wait_done();

    // Backpressure with the reader stalled
    hold = 1;
    push_one_to_one(8);
    start_frame(3, 8, 8, 'h4000);
    for (int i = 0; i < 300 && fill_cnt != FW'(3); i++) @(negedge clk);
    repeat (20) @(negedge clk);
    check("bp_fill", int'(fill_cnt), 3);
    check("bp_in_ready_low", int'(in_ready), 0);
    check("bp_line_valid", int'(lv), 1);
    hold = 0;
    for (int i = 0; i < 300 && fill_cnt == FW'(3); i++) @(negedge clk);
    check("bp_in_ready_resume", int'(in_ready), 1);
    wait_done();

    // Oversized step clamps to 2.0; a start while busy must be ignored
    repeat (4) push_line(0, 1'b0);
    repeat (3) q_adv.push_back(2);
    repeat (2) q_adv.push_back(1);
    start_frame(3, 8, 4, 'h9000);
    repeat (30) @(posedge clk);
    check("busy_mid_frame", int'(busy), 1);
    in_height = LW'(1);
    out_height = LW'(1);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done();

    // Zero step is treated as one LSB
    push_line(0, 1'b0);
    push_line(1, 1'b0);
    push_line(2, 1'b0);
    repeat (2) q_adv.push_back(1);
    start_frame(3, 2, 3, 0);
    wait_done();

    // Reset mid-line, then a clean 1:1 frame
    start_frame(3, 4, 4, 'h4000);
    for (int i = 0; i < 200 && !(we && waddr == AW'(2)); i++) @(negedge clk);
    do_reset();
    check("rst_outputs", int'(|{in_ready, we, waddr, aw, r1, r2, fr, lv, frac, busy, fd}), 0);
    push_one_to_one(4);
    start_frame(3, 4, 4, 'h4000);
    wait_done();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/line_fifo_sequencer.md
Name: line_fifo_sequencer

Overview:
- Controller for the multi-line RAM FIFO in the vertical scaling path.
- Write side: accepts input pixel stream; generates write address, write enable and advance-write per completed input line.
- Read side: fixed-point vertical position accumulator; presents each output line's line pair to the downstream horizontal reader; advances the FIFO by 0, 1 or 2 lines per output line.
- Drives force-read at end of frame and drains the FIFO before signalling frame completion.

Parameters:
DATA_WIDTH, 8, pixel width
ADDRESS_WIDTH, 10, FIFO RAM address width; max line length 2**ADDRESS_WIDTH
BUFFER_SIZE, 4, number of line RAMs in the FIFO (min 3)
FILL_WIDTH, 3, width of FIFO fill count (holds BUFFER_SIZE+1)
SCALE_FRAC, 14, fractional bits of v_step and line_frac
LINES_WIDTH, 11, width of line-count configuration

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  pulse; latches config, begins frame (ignored while busy)
in_width  in  ADDRESS_WIDTH  pixels per input line minus 1
in_height  in  LINES_WIDTH  input lines per frame (>=1)
out_height  in  LINES_WIDTH  output lines per frame (>=1)
v_step  in  SCALE_FRAC+2  input lines per output line, unsigned fixed point
in_valid  in  1  input pixel valid
in_data  in  DATA_WIDTH  input pixel
in_ready  out  1  input pixel accepted when in_valid & in_ready
fifo_write_data  out  DATA_WIDTH  = in_data
fifo_write_address  out  ADDRESS_WIDTH  pixel column
fifo_write_enable  out  1  = in_valid & in_ready
fifo_advance_write  out  1  pulse after last pixel of a line
fifo_advance_read1  out  1  pulse, advance read by one line
fifo_advance_read2  out  1  pulse, advance read by two lines
fifo_force_read  out  1  disables FIFO writes; permits reading the write RAM
fifo_fill_count  in  FILL_WIDTH  completed lines held in FIFO
line_valid  out  1  line pair available to downstream reader
line_frac  out  SCALE_FRAC  vertical blend weight of second line
line_done  in  1  pulse from reader, output line finished
busy  out  1  high from accepted start until frame_done
frame_done  out  1  single-cycle pulse at end of frame

Behaviour:
- Reset: all outputs 0, write column 0, line counters 0, y_frac 0, FSM IDLE. Reset mid-frame abandons the frame; the FIFO is reset by the same rst.
- start in IDLE: latch config; clamp v_step to [1 LSB, 2.0] (2.0 = 2<<SCALE_FRAC); busy=1; go to WAIT.
- Write side (independent of read FSM while busy):
  - in_ready = busy & input_lines_written < in_height & fifo_fill_count < BUFFER_SIZE-1 & !adv_write_q.
  - adv_write_q = registered fifo_advance_write; it blocks writes for one cycle while fill count settles.
  - Each accepted pixel: address increments.
  - Accepted pixel at address == in_width: address wraps to 0; fifo_advance_write=1 next cycle; input_lines_written+1.
- input_complete = input_lines_written == in_height. fifo_force_read = busy & input_complete.
- Read FSM states:
  - WAIT → READY when fifo_fill_count >= 2, or input_complete & fifo_fill_count >= 1.
  - READY: line_valid=1; line_frac = y_frac, forced to 0 when fifo_fill_count == 1 (bottom edge).
  - READY on line_done: line_valid=0 next cycle; output_lines+1.
    - If output_lines reaches out_height → DRAIN.
    - Otherwise: sum = y_frac + v_step; delta = sum >> SCALE_FRAC (0..2); y_frac <= sum[SCALE_FRAC-1:0] → ADV.
  - ADV (1 cycle):
    - If input_complete, clamp delta to fifo_fill_count-1.
    - delta 1 → advance_read1 pulse; delta 2 → advance_read2 pulse; delta 0 → no pulse.
    - Go to SETTLE.
  - SETTLE (1 cycle, fill count update) → WAIT.
  - DRAIN:
    - Input continues to be accepted and discarded by advancing.
    - Pulse advance_read1 every other cycle while fifo_fill_count > 0.
    - When input_complete & fifo_fill_count == 0 & no pulse in flight → DONE.
  - DONE: frame_done=1 for one cycle; busy=0 → IDLE.
- Never assert advance_read1 and advance_read2 together. Never advance read past fill count. No read advance on the same cycle as advance_write.
- line_done outside READY is ignored.

Test Plan:
1. BUFFER_SIZE=4, SCALE_FRAC=14; in_width=3, in_height=4, out_height=4, v_step=0x4000 → 4 line_valid periods, line_frac=0 each, advance_read1 after lines 1-3, drain, frame_done once, busy falls same cycle.
2. v_step=0x2000, in_height=4, out_height=8 → line_frac sequence 0,0x2000 repeating; advance_read1 after every second line_done; last line line_frac=0 with force_read=1.
3. v_step=0x8000, in_height=8, out_height=4 → advance_read2 after each of lines 1-3, never advance_read1 before DRAIN.
4. Backpressure: in_valid held high, line_done withheld → in_ready low once fill_count=3; resumes one cycle after fill drops; write addresses 0..3 contiguous per line.
5. v_step=0x9000 → clamped to 0x8000; v_step=0 → treated as 1 LSB; start while busy ignored.
6. rst asserted mid-line → next cycle all outputs 0, FSM IDLE; new start completes a normal 1:1 frame.
